// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Holds FSM states, opcode constants, select encodings and control bundles.
package control_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALTED = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic       ADDR_SEL_PC     = 1'b0;
    localparam logic       ADDR_SEL_RESULT = 1'b1;

    localparam logic [1:0] RD_SEL_ALU  = 2'd0;
    localparam logic [1:0] RD_SEL_LOAD = 2'd1;
    localparam logic [1:0] RD_SEL_PC4  = 2'd2;
    localparam logic [1:0] RD_SEL_CSR  = 2'd3;

    localparam logic [1:0] INSEL1_RS1  = 2'd0;
    localparam logic [1:0] INSEL1_PC   = 2'd1;
    localparam logic [1:0] INSEL1_ZERO = 2'd2;

    localparam logic [1:0] INSEL2_RS2  = 2'd0;
    localparam logic [1:0] INSEL2_IMM  = 2'd1;
    localparam logic [1:0] INSEL2_FOUR = 2'd2;

    localparam logic       PC_SEL_PC4 = 1'b0;
    localparam logic       PC_SEL_ALU = 1'b1;

    // Branches pick their PC source from the comparator at EXEC time.
    typedef enum logic [1:0] {
        PC_SRC_PC4 = 2'd0,
        PC_SRC_ALU = 2'd1,
        PC_SRC_CMP = 2'd2
    } pc_src_t;

    typedef struct packed {
        logic       store;
        logic       write_rd;
        logic       write_csr;
        logic       write_pc;
        logic [1:0] rd_sel;
        logic [1:0] alu_insel1;
        logic [1:0] alu_insel2;
        pc_src_t    pc_src;
    } exec_ctrl_t;

    typedef struct packed {
        logic       store;
        logic       write_pc;
        logic       write_ir;
        logic       write_rd;
        logic       write_csr;
        logic       mem_read;
        logic       mem_write;
        logic       addr_sel;
        logic [1:0] rd_sel;
        logic [1:0] alu_insel1;
        logic [1:0] alu_insel2;
        logic       pc_sel;
        logic       halted;
    } ctrl_bundle_t;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction classifier: legality, whether EXEC hands off to MEM,
// and the strobe/select vector driven during EXEC.
module control_decode
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    output logic       legal,
    output logic       to_mem,
    output logic       is_load,
    output exec_ctrl_t exec_ctrl
);

    always_comb begin
        legal     = 1'b1;
        to_mem    = 1'b0;
        is_load   = 1'b0;
        exec_ctrl = '0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                exec_ctrl.alu_insel1 = INSEL1_RS1;
                exec_ctrl.alu_insel2 = (opcode == OPC_OP_IMM) ? INSEL2_IMM : INSEL2_RS2;
                exec_ctrl.rd_sel     = RD_SEL_ALU;
                exec_ctrl.write_rd   = 1'b1;
                exec_ctrl.write_pc   = 1'b1;
                exec_ctrl.pc_src     = PC_SRC_PC4;
            end
            OPC_LUI, OPC_AUIPC: begin
                exec_ctrl.alu_insel1 = (opcode == OPC_LUI) ? INSEL1_ZERO : INSEL1_PC;
                exec_ctrl.alu_insel2 = INSEL2_IMM;
                exec_ctrl.rd_sel     = RD_SEL_ALU;
                exec_ctrl.write_rd   = 1'b1;
                exec_ctrl.write_pc   = 1'b1;
                exec_ctrl.pc_src     = PC_SRC_PC4;
            end
            OPC_JAL, OPC_JALR: begin
                exec_ctrl.alu_insel1 = (opcode == OPC_JAL) ? INSEL1_PC : INSEL1_RS1;
                exec_ctrl.alu_insel2 = INSEL2_IMM;
                exec_ctrl.rd_sel     = RD_SEL_PC4;
                exec_ctrl.write_rd   = 1'b1;
                exec_ctrl.write_pc   = 1'b1;
                exec_ctrl.pc_src     = PC_SRC_ALU;
            end
            OPC_BRANCH: begin
                exec_ctrl.alu_insel1 = INSEL1_PC;
                exec_ctrl.alu_insel2 = INSEL2_IMM;
                exec_ctrl.write_pc   = 1'b1;
                exec_ctrl.pc_src     = PC_SRC_CMP;
            end
            OPC_LOAD, OPC_STORE: begin
                exec_ctrl.alu_insel1 = INSEL1_RS1;
                exec_ctrl.alu_insel2 = INSEL2_IMM;
                exec_ctrl.store      = 1'b1;
                to_mem               = 1'b1;
                is_load              = (opcode == OPC_LOAD);
                // Only byte/half/word (and their unsigned loads) exist in RV32I.
                if (opcode == OPC_LOAD)
                    legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
                else
                    legal = (f3 <= 3'b010);
            end
            OPC_SYSTEM: begin
                exec_ctrl.rd_sel    = RD_SEL_CSR;
                exec_ctrl.write_rd  = 1'b1;
                exec_ctrl.write_csr = 1'b1;
                exec_ctrl.write_pc  = 1'b1;
                exec_ctrl.pc_src    = PC_SRC_PC4;
                legal               = !(f3 == 3'b000 || f3 == 3'b100);
            end
            OPC_MISC_MEM: begin
                exec_ctrl.write_pc = 1'b1;
                exec_ctrl.pc_src   = PC_SRC_PC4;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I control unit: sequences fetch/decode/exec/mem/wb, owns the
// debug halt boundary and the sticky illegal-instruction flag.
module control_fsm
    import control_pkg::*;
#(
    parameter bit HALT_ON_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic       mem_complete_read,
    input  logic       mem_complete_write,
    input  logic       cmp_true,
    input  logic       halt_req,
    input  logic       resume_req,
    output logic       store,
    output logic       write_pc,
    output logic       write_ir,
    output logic       write_rd,
    output logic       write_csr,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic [1:0] rd_sel,
    output logic [1:0] alu_insel1,
    output logic [1:0] alu_insel2,
    output logic       pc_sel,
    output logic       halted,
    output logic       illegal_insn
);

    state_t       state_q, state_d;
    logic         illegal_q, illegal_d;
    logic         insn_legal;
    logic         exec_to_mem;
    logic         exec_is_load;
    logic         retire;
    exec_ctrl_t   exec_ctrl;
    ctrl_bundle_t ctrl;

    control_decode u_decode (
        .opcode    (opcode),
        .f3        (f3),
        .legal     (insn_legal),
        .to_mem    (exec_to_mem),
        .is_load   (exec_is_load),
        .exec_ctrl (exec_ctrl)
    );

    always_comb begin
        ctrl      = '0;
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            IDLE: state_d = (halt_req || HALT_ON_RESET) ? HALTED : FETCH;
            FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.addr_sel = ADDR_SEL_PC;
                if (mem_complete_read) begin
                    ctrl.write_ir = 1'b1;
                    state_d       = DECODE;
                end
            end
            DECODE: begin
                if (insn_legal) begin
                    state_d = EXEC;
                end else begin
                    state_d   = HALTED;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                ctrl.store      = exec_ctrl.store;
                ctrl.write_rd   = exec_ctrl.write_rd;
                ctrl.write_csr  = exec_ctrl.write_csr;
                ctrl.write_pc   = exec_ctrl.write_pc;
                ctrl.rd_sel     = exec_ctrl.rd_sel;
                ctrl.alu_insel1 = exec_ctrl.alu_insel1;
                ctrl.alu_insel2 = exec_ctrl.alu_insel2;
                case (exec_ctrl.pc_src)
                    PC_SRC_ALU: ctrl.pc_sel = PC_SEL_ALU;
                    PC_SRC_CMP: ctrl.pc_sel = cmp_true;
                    default:    ctrl.pc_sel = PC_SEL_PC4;
                endcase
                if (exec_to_mem)
                    state_d = MEM;
                else
                    retire = 1'b1;
            end
            MEM: begin
                ctrl.addr_sel = ADDR_SEL_RESULT;
                if (exec_is_load) begin
                    ctrl.mem_read = 1'b1;
                    if (mem_complete_read)
                        state_d = WB;
                end else begin
                    ctrl.mem_write = 1'b1;
                    if (mem_complete_write) begin
                        ctrl.write_pc = 1'b1;
                        ctrl.pc_sel   = PC_SEL_PC4;
                        retire        = 1'b1;
                    end
                end
            end
            WB: begin
                ctrl.rd_sel   = RD_SEL_LOAD;
                ctrl.write_rd = 1'b1;
                ctrl.write_pc = 1'b1;
                ctrl.pc_sel   = PC_SEL_PC4;
                retire        = 1'b1;
            end
            HALTED: begin
                ctrl.halted = 1'b1;
                if (resume_req && !halt_req) begin
                    state_d   = FETCH;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Halt requests are only honoured at an instruction boundary.
        if (retire)
            state_d = halt_req ? HALTED : FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign store        = ctrl.store;
    assign write_pc     = ctrl.write_pc;
    assign write_ir     = ctrl.write_ir;
    assign write_rd     = ctrl.write_rd;
    assign write_csr    = ctrl.write_csr;
    assign mem_read     = ctrl.mem_read;
    assign mem_write    = ctrl.mem_write;
    assign addr_sel     = ctrl.addr_sel;
    assign rd_sel       = ctrl.rd_sel;
    assign alu_insel1   = ctrl.alu_insel1;
    assign alu_insel2   = ctrl.alu_insel2;
    assign pc_sel       = ctrl.pc_sel;
    assign halted       = ctrl.halted;
    assign illegal_insn = illegal_q;

endmodule
